// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//
// Far end of the CPU fetch interface. It accepts one word-addressed fetch at a
// time and reads a program-loadable instruction RAM. After WAIT_STATES extra
// cycles it returns the instruction through a valid/ready handshake. A redirect
// flush discards any outstanding fetch, so no stale instruction reaches decode.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset (RAM contents are kept)
//   req_valid  fetch request present
//   req_addr   word address to fetch
//   req_ready  responder can accept a request this cycle (combinational)
//   rsp_valid  instruction response present
//   rsp_ready  fetch stage consumes the response
//   rsp_instr  fetched instruction, 0 (NOP) on error
//   rsp_addr   address the response belongs to
//   rsp_err    requested address was >= DEPTH
//   flush      redirect, discards any outstanding fetch
//   load_we    program-loader write strobe
//   load_addr  loader word address; writes with load_addr >= DEPTH are dropped
//   load_data  loader write data
module imem_fetch_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_word;
  logic              cap_ok;

  // Unsigned compare across the full address width; one extra bit keeps
  // DEPTH representable even when it equals 2**ADDR_W.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  assign req_ready = (state == S_IDLE) & ~flush & ~load_we;
  assign accept    = req_valid & req_ready;

  // With zero wait states the capture happens on the accept edge itself, so
  // the address comes straight from the request instead of the latch.
  assign cap_addr = (state == S_IDLE) ? req_addr : lat_addr;
  assign cap_ok   = in_range(cap_addr);
  assign cap_word = cap_ok ? mem[cap_addr[IDX_W-1:0]] : '0;

  // Loader port. The capture below reads the pre-edge contents, which gives
  // read-before-write behaviour for a load hitting the captured address.
  always_ff @(posedge clk) begin
    if (load_we && in_range(load_addr)) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else if (flush) begin
      // Any in-flight or held response is dropped, even if rsp_ready is high.
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr <= req_addr;
            cnt      <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_instr <= cap_word;
              rsp_addr  <= cap_addr;
              rsp_err   <= ~cap_ok;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // The <= also covers a counter that somehow reached 0.
          if (cnt <= 4'd1) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_instr <= cap_word;
            rsp_addr  <= cap_addr;
            rsp_err   <= ~cap_ok;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        load_we;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  // Instance with one wait state
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_instr;
  logic [15:0] rsp_addr;
  logic        rsp_err;

  // Instance with zero wait states
  logic        req_valid_z;
  logic [15:0] req_addr_z;
  logic        req_ready_z;
  logic        rsp_valid_z;
  logic        rsp_ready_z;
  logic [15:0] rsp_instr_z;
  logic [15:0] rsp_addr_z;
  logic        rsp_err_z;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  imem_fetch_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  imem_fetch_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) dutz (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_addr(req_addr_z), .req_ready(req_ready_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_instr(rsp_instr_z),
    .rsp_addr(rsp_addr_z), .rsp_err(rsp_err_z), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  // Full fetch on the one-wait-state instance with rsp_ready held high:
  // accept cycle, one WAIT cycle, one RESP cycle, then back to IDLE.
  task automatic do_fetch(input string name, input logic [15:0] a,
                          input logic [15:0] exp_i, input logic exp_e);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    #1;
    chk({name, " req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk({name, " wait rsp_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " rsp_instr"}, 32'(rsp_instr), 32'(exp_i));
    chk({name, " rsp_addr"}, 32'(rsp_addr), 32'(a));
    chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
    chk({name, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] bb [4];
    bb[0] = 16'h1111; bb[1] = 16'h2222; bb[2] = 16'h3333; bb[3] = 16'h4444;

    vecs[0] = '{"fetch 2",      16'h0002, 16'h3333, 1'b0};
    vecs[1] = '{"fetch 0",      16'h0000, 16'h1111, 1'b0};
    vecs[2] = '{"fetch 3",      16'h0003, 16'h4444, 1'b0};
    vecs[3] = '{"fetch 1",      16'h0001, 16'h2222, 1'b0};
    vecs[4] = '{"fetch 255",    16'h00FF, 16'hABCD, 1'b0};
    vecs[5] = '{"fetch 0x100",  16'h0100, 16'h0000, 1'b1};
    vecs[6] = '{"fetch 0xFFFF", 16'hFFFF, 16'h0000, 1'b1};
    vecs[7] = '{"fetch 0 again", 16'h0000, 16'h1111, 1'b0};

    rst = 1'b1; flush = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    req_valid_z = 1'b0; req_addr_z = '0; rsp_ready_z = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_instr", 32'(rsp_instr), 32'd0);
    chk("reset rsp_addr", 32'(rsp_addr), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset req_ready_z", 32'(req_ready_z), 32'd1);

    load(16'h0000, 16'h1111);
    load(16'h0001, 16'h2222);
    load(16'h0002, 16'h3333);
    load(16'h0003, 16'h4444);
    load(16'h0005, 16'h7777);
    load(16'h00FF, 16'hABCD);
    load(16'h0100, 16'hBEEF);  // out of range, must not alias onto RAM[0]

    for (int i = 0; i < 8; i++) begin
      do_fetch(vecs[i].name, vecs[i].addr, vecs[i].instr, vecs[i].err);
    end

    // Zero wait states: back-to-back fetches, one response every 2 cycles.
    req_valid_z = 1'b1;
    rsp_ready_z = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr_z = 16'(k);
      #1;
      chk($sformatf("b2b %0d req_ready", k), 32'(req_ready_z), 32'd1);
      tick();
      chk($sformatf("b2b %0d rsp_valid", k), 32'(rsp_valid_z), 32'd1);
      chk($sformatf("b2b %0d rsp_instr", k), 32'(rsp_instr_z), 32'(bb[k]));
      chk($sformatf("b2b %0d rsp_addr", k), 32'(rsp_addr_z), k);
      if (k == 3) req_valid_z = 1'b0;
      #1;
      chk($sformatf("b2b %0d busy req_ready", k), 32'(req_ready_z), 32'd0);
      tick();
      chk($sformatf("b2b %0d idle rsp_valid", k), 32'(rsp_valid_z), 32'd0);
    end

    // Back-pressure: hold rsp_ready low for 5 RESP cycles.
    req_valid = 1'b1; req_addr = 16'h0001; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold %0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold %0d rsp_instr", i), 32'(rsp_instr), 32'h2222);
      chk($sformatf("hold %0d req_ready", i), 32'(req_ready), 32'd0);
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("hold release req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("hold idle rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold idle req_ready", 32'(req_ready), 32'd1);

    // Flush during WAIT.
    req_valid = 1'b1; req_addr = 16'h0003; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush wait req_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush wait rsp_valid", 32'(rsp_valid), 32'd0);
    do_fetch("after flush wait", 16'h0000, 16'h1111, 1'b0);

    // Flush during RESP with rsp_ready low.
    req_valid = 1'b1; req_addr = 16'h0002; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("flush resp pre rsp_valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush resp rsp_valid", 32'(rsp_valid), 32'd0);
    do_fetch("after flush resp", 16'h0003, 16'h4444, 1'b0);

    // Read-before-write: load the captured address in the capture cycle.
    req_valid = 1'b1; req_addr = 16'h0005; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    load_we = 1'b1; load_addr = 16'h0005; load_data = 16'h8888;
    tick();
    load_we = 1'b0;
    chk("rbw rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rbw old rsp_instr", 32'(rsp_instr), 32'h7777);
    tick();
    do_fetch("rbw new", 16'h0005, 16'h8888, 1'b0);

    // Loader blocks request acceptance.
    req_valid = 1'b1; req_addr = 16'h0002; rsp_ready = 1'b1;
    load_we = 1'b1; load_addr = 16'h000A; load_data = 16'h5555;
    #1;
    chk("load blk0 req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("load blk0 rsp_valid", 32'(rsp_valid), 32'd0);
    load_addr = 16'h000B; load_data = 16'h6666;
    #1;
    chk("load blk1 req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("load blk1 rsp_valid", 32'(rsp_valid), 32'd0);
    load_we = 1'b0;
    #1;
    chk("load done req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("load acc wait rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("load acc rsp_valid", 32'(rsp_valid), 32'd1);
    chk("load acc rsp_instr", 32'(rsp_instr), 32'h3333);
    chk("load acc rsp_addr", 32'(rsp_addr), 32'h0002);
    tick();
    do_fetch("loaded 11", 16'h000B, 16'h6666, 1'b0);
    do_fetch("loaded 10", 16'h000A, 16'h5555, 1'b0);

    // Reset during WAIT drops the pending fetch and clears the outputs.
    req_valid = 1'b1; req_addr = 16'h0003; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst wait rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst wait rsp_instr", 32'(rsp_instr), 32'd0);
    chk("rst wait rsp_addr", 32'(rsp_addr), 32'd0);
    chk("rst wait rsp_err", 32'(rsp_err), 32'd0);
    chk("rst wait req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rst lost rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rst lost2 rsp_valid", 32'(rsp_valid), 32'd0);
    do_fetch("after rst", 16'h0001, 16'h2222, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
